rv32_data_bus: RTL and testbench
================================

// Module: rv32_data_bus
// PURPOSE
// - Parametrised data-side interconnect between rv32_core and NUM_TARGETS slaves
//   (target 0 = main memory, 1.. = MMIO).
// - Decodes the core data request address into one target and tracks a single
//   outstanding transaction; returns the selected target's data with its done pulse.
// - Adds what the fixed 2-MMIO mux lacked: address decode, unmapped-address error
//   response, per-transaction timeout and a busy/stall indication.
// PARAMETERS
// - NUM_TARGETS   2                    number of slaves, >=1
// - BASE_ADDR     '{32'h0,32'h8000_0000} per-target base address, rv32_word array
// - ADDR_MASK     '{32'hF000_0000,32'hF000_0000} per-target decode mask
// - TIMEOUT_CYC   64                   wait cycles before error response; 0 = disabled
// - ERR_DATA      32'hDEAD_BEEF        data returned on unmapped/timeout error
// PORTS
// - clk             in   1                  clock, rising edge
// - resetn          in   1                  async active-low reset
// - core_req        in   memory_request_t   core data request (.valid, .addr, rest opaque)
// - core_done       out  1                  one-cycle completion pulse to core
// - core_data       out  32                 read data, valid when core_done=1
// - core_err        out  1                  high with core_done on unmapped/timeout
// - busy            out  1                  transaction outstanding; core must not issue
// - tgt_req         out  memory_request_t[NUM_TARGETS]  per-target request, .valid gated
// - tgt_done        in   1[NUM_TARGETS]     per-target completion pulse
// - tgt_data        in   32[NUM_TARGETS]    per-target read data, valid with tgt_done
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE, core_done=0, core_err=0, core_data=0,
//   busy=0, all tgt_req[i].valid=0, timeout counter=0, sel=0.
// - Decode: hit[i] = ((addr & ADDR_MASK[i]) == BASE_ADDR[i]); lowest index wins on
//   overlap; no hit -> unmapped.
// - FSM states: IDLE, WAIT, RESP.
//   IDLE: core_req.valid & hit -> latch sel, forward request to tgt_req[sel] this
//     same cycle (combinational pass, .valid high exactly 1 cycle) -> WAIT.
//     core_req.valid & unmapped -> RESP with err=1.
//   WAIT: busy=1; tgt_done[sel] -> register tgt_data[sel] -> RESP (err=0).
//     counter reaches TIMEOUT_CYC-1 without done -> RESP with err=1.
//   RESP: core_done=1 for exactly one cycle, core_data = latched data (ERR_DATA on
//     err), core_err = err; -> IDLE. New request accepted the cycle after RESP.
// - Latency: mapped target answering N cycles after its request -> core_done at
//   N+1 (one registered stage); unmapped -> core_done 1 cycle after request.
// - tgt_done from a non-selected target, or in IDLE/RESP, is ignored (no effect).
// - Late tgt_done[sel] after timeout is ignored; no second core_done.
// - Simultaneous tgt_done[sel] and timeout expiry: done wins, err=0.
// - core_req.valid while busy: ignored, never forwarded (protocol violation;
//   assertion in bench).
// - Counter is $clog2(TIMEOUT_CYC+1) bits; cleared on entry to WAIT; saturates.
// - Reset mid-transaction: immediate return to reset values; pending target
//   response after reset is ignored.
// - core_data is 0 whenever core_done=0.
// STRUCTURE
// - rv32_types: add bus_state_t enum (IDLE/WAIT/RESP) and BUS_ERR_DATA constant.
// - One sub-module: rv32_addr_decoder (combinational, parametrised BASE/MASK ->
//   one-hot hit vector + unmapped flag + encoded index); FSM, counter and response
//   register live in rv32_data_bus.
// TESTING
// - Read addr 0x0000_0010, tgt_done[0] 3 cycles later with 0x1234_5678
//   -> core_done at cycle 4, core_data=0x1234_5678, core_err=0.
// - Read 0x8000_0004, tgt_done[1] same cycle as request with 0xA5A5_A5A5
//   -> tgt_req[1].valid for 1 cycle only, core_done next cycle, data=0xA5A5_A5A5.
// - Read 0x4000_0000 (unmapped) -> no tgt_req valid, core_done+core_err after
//   1 cycle, data=0xDEAD_BEEF.
// - Target 1 never responds, TIMEOUT_CYC=64 -> core_done+core_err at WAIT cycle 64;
//   later tgt_done[1] produces no core_done.
// - Spurious tgt_done[0]=1 with data 0xFFFF_FFFF while waiting on target 1
//   -> ignored; only target 1's data returned.
// - resetn=0 in WAIT, then release, then tgt_done[0] -> outputs stay at reset
//   values, no core_done.

Source files
------------

// File: rtl/rv32_data_bus_pkg.sv
// Shared types and constants for the rv32 data-side interconnect: request
// record, FSM state encoding and sizing helpers.
package rv32_data_bus_pkg;

   typedef logic [31:0] rv32_word;

   typedef struct packed {
      logic     valid;
      rv32_word addr;
      rv32_word wdata;
      logic [3:0] wstrb;
      logic     we;
   } memory_request_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } bus_state_t;

   localparam rv32_word BUS_ERR_DATA = 32'hDEAD_BEEF;

   // Index width that stays legal for a single-target build.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/rv32_data_bus_if.sv
// Core/target signal bundle of the data interconnect. The slave modport is the
// interconnect's view; master is the view of whatever drives the core and targets.
interface rv32_data_bus_if #(
   parameter int NUM_TARGETS = 2
) ();
   import rv32_data_bus_pkg::*;

   memory_request_t                        core_req;
   logic                                   core_done;
   rv32_word                               core_data;
   logic                                   core_err;
   logic                                   busy;
   memory_request_t [NUM_TARGETS-1:0]      tgt_req;
   logic [NUM_TARGETS-1:0]                 tgt_done;
   logic [NUM_TARGETS-1:0][31:0]           tgt_data;

   modport slave (
      input  core_req, tgt_done, tgt_data,
      output core_done, core_data, core_err, busy, tgt_req
   );

   modport master (
      output core_req, tgt_done, tgt_data,
      input  core_done, core_data, core_err, busy, tgt_req
   );

endinterface

// File: rtl/rv32_data_bus_decoder.sv
// Combinational base/mask address decoder: lowest-index hit wins, reported as
// a one-hot vector plus its encoded index, with an unmapped flag when nothing hits.
module rv32_data_bus_decoder
   import rv32_data_bus_pkg::*;
#(
   parameter int       NUM_TARGETS = 2,
   parameter rv32_word BASE_ADDR [NUM_TARGETS] = '{default: 32'h0},
   parameter rv32_word ADDR_MASK [NUM_TARGETS] = '{default: 32'hF000_0000},
   parameter int       IDX_W = idx_width(NUM_TARGETS)
) (
   input  rv32_word               addr,
   output logic [NUM_TARGETS-1:0] hit_onehot,
   output logic                   unmapped,
   output logic [IDX_W-1:0]       idx
);

   logic [NUM_TARGETS-1:0] hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_hit
         assign hit[gi] = ((addr & ADDR_MASK[gi]) == BASE_ADDR[gi]);
      end
   endgenerate

   // Scan downwards so the lowest matching index is the last one written.
   always_comb begin
      idx = '0;
      for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

   assign unmapped = ~|hit;

   generate
      for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_onehot
         assign hit_onehot[gi] = hit[gi] && (idx == IDX_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/rv32_data_bus.sv
// Data-side interconnect between the core and NUM_TARGETS slaves: decodes,
// forwards one request at a time, and answers with data, unmapped or timeout error.
module rv32_data_bus
   import rv32_data_bus_pkg::*;
#(
   parameter int       NUM_TARGETS = 2,
   parameter rv32_word BASE_ADDR [NUM_TARGETS] = '{32'h0, 32'h8000_0000},
   parameter rv32_word ADDR_MASK [NUM_TARGETS] = '{32'hF000_0000, 32'hF000_0000},
   parameter int       TIMEOUT_CYC = 64,
   parameter rv32_word ERR_DATA = BUS_ERR_DATA
) (
   input  logic            clk,
   input  logic            resetn,
   rv32_data_bus_if.slave  bus
);

   localparam int IDX_W    = idx_width(NUM_TARGETS);
   localparam int CNT_W    = cnt_width(TIMEOUT_CYC);
   localparam int LAST_INT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);

   bus_state_t       state_reg, state_next;
   logic [IDX_W-1:0] sel_reg, sel_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   rv32_word         data_reg, data_next;
   logic             err_reg, err_next;

   logic [NUM_TARGETS-1:0] dec_onehot;
   logic                   dec_unmapped;
   logic [IDX_W-1:0]       dec_idx;
   logic                   accept;
   logic                   timeout_hit;
   memory_request_t        req_fwd;
   memory_request_t        req_idle;

   rv32_data_bus_decoder #(
      .NUM_TARGETS (NUM_TARGETS),
      .BASE_ADDR   (BASE_ADDR),
      .ADDR_MASK   (ADDR_MASK),
      .IDX_W       (IDX_W)
   ) u_decoder (
      .addr       (bus.core_req.addr),
      .hit_onehot (dec_onehot),
      .unmapped   (dec_unmapped),
      .idx        (dec_idx)
   );

   // Gating with resetn keeps every target quiet while reset is held.
   assign accept      = resetn && bus.core_req.valid && (state_reg == IDLE) && !dec_unmapped;
   assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_reg == CNT_LAST);

   always_comb begin
      req_fwd        = bus.core_req;
      req_fwd.valid  = accept;
      req_idle       = bus.core_req;
      req_idle.valid = 1'b0;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_tgt
         assign bus.tgt_req[gi] = dec_onehot[gi] ? req_fwd : req_idle;
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      cnt_next   = cnt_reg;
      data_next  = data_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (bus.core_req.valid) begin
               if (dec_unmapped) begin
                  state_next = RESP;
                  data_next  = ERR_DATA;
                  err_next   = 1'b1;
               end else begin
                  sel_next = dec_idx;
                  cnt_next = '0;
                  err_next = 1'b0;
                  // A combinational target may answer in the request cycle itself.
                  if (bus.tgt_done[dec_idx]) begin
                     data_next  = bus.tgt_data[dec_idx];
                     state_next = RESP;
                  end else begin
                     state_next = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            if (bus.tgt_done[sel_reg]) begin
               data_next  = bus.tgt_data[sel_reg];
               err_next   = 1'b0;
               state_next = RESP;
            end else if (timeout_hit) begin
               data_next  = ERR_DATA;
               err_next   = 1'b1;
               state_next = RESP;
            end else if (cnt_reg != '1) begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= IDLE;
         sel_reg   <= '0;
         cnt_reg   <= '0;
         data_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
         cnt_reg   <= cnt_next;
         data_reg  <= data_next;
         err_reg   <= err_next;
      end
   end

   assign bus.core_done = (state_reg == RESP);
   assign bus.core_err  = (state_reg == RESP) && err_reg;
   assign bus.core_data = (state_reg == RESP) ? data_reg : '0;
   assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_rv32_data_bus.sv
// Bench for rv32_data_bus: hand-tabulated vectors, reset corner cases and
// randomized transactions checked against a latency/decode reference model.
module tb_rv32_data_bus;
   import rv32_data_bus_pkg::*;

   localparam int          NT   = 2;
   localparam int          TMO  = 64;
   localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [31:0] addr;
      int          delay;
      logic [31:0] rdata;
      bit          spur;
      int          e_tgt;
      int          e_lat;
      bit          e_err;
      logic [31:0] e_data;
   } vec_t;

   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] base_m [NT] = '{32'h0000_0000, 32'h8000_0000};
   logic [31:0] mask_m [NT] = '{32'hF000_0000, 32'hF000_0000};

   rv32_data_bus_if #(.NUM_TARGETS(NT)) bus ();

   rv32_data_bus #(
      .NUM_TARGETS (NT),
      .BASE_ADDR   ('{32'h0000_0000, 32'h8000_0000}),
      .ADDR_MASK   ('{32'hF000_0000, 32'hF000_0000}),
      .TIMEOUT_CYC (TMO),
      .ERR_DATA    (DEAD)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // The core must never issue while the interconnect is busy.
   always @(negedge clk) begin
      if (resetn && bus.busy && bus.core_req.valid) begin
         errors++;
         $display("FAIL protocol core_req.valid=1 while busy=1 (required 0)");
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int id, input int cyc,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s txn %0d cyc %0d got %h want %h", nm, id, cyc, act, exp);
      end
   endtask

   function automatic logic [NT-1:0] tgt_valids();
      logic [NT-1:0] v;
      for (int i = 0; i < NT; i++) v[i] = bus.tgt_req[i].valid;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: decode by base/mask, then latency is response delay + 1,
   // capped by the timeout; unmapped answers in one cycle.
   function automatic vec_t model(input logic [31:0] addr, input int delay,
                                  input logic [31:0] rdata, input bit spur);
      vec_t v;
      v.addr  = addr;
      v.delay = delay;
      v.rdata = rdata;
      v.spur  = spur;
      v.e_tgt = -1;
      for (int i = NT - 1; i >= 0; i--)
         if ((addr & mask_m[i]) == base_m[i]) v.e_tgt = i;
      if (v.e_tgt < 0) begin
         v.e_lat = 1; v.e_err = 1'b1; v.e_data = DEAD;
      end else if (delay >= 0 && delay <= TMO) begin
         v.e_lat = delay + 1; v.e_err = 1'b0; v.e_data = rdata;
      end else begin
         v.e_lat = TMO + 1; v.e_err = 1'b1; v.e_data = DEAD;
      end
      return v;
   endfunction

   task automatic drive_noise();
      for (int i = 0; i < NT; i++) begin
         bus.tgt_done[i] = 1'b0;
         bus.tgt_data[i] = 32'($urandom);
      end
      bus.core_req.addr  = 32'($urandom);
      bus.core_req.wdata = 32'($urandom);
      bus.core_req.wstrb = 4'($urandom);
      bus.core_req.we    = 1'($urandom);
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int last;
      last = ((v.delay > v.e_lat) ? v.delay : v.e_lat) + 2;
      for (int c = 0; c <= last; c++) begin
         drive_noise();
         bus.core_req.valid = (c == 0);
         if (c == 0) bus.core_req.addr = v.addr;
         if (v.spur) begin
            for (int i = 0; i < NT; i++) begin
               if (i != v.e_tgt) begin
                  bus.tgt_done[i] = 1'b1;
                  bus.tgt_data[i] = 32'hFFFF_FFFF;
               end
            end
         end
         if (v.e_tgt >= 0 && c == v.delay) begin
            bus.tgt_done[v.e_tgt] = 1'b1;
            bus.tgt_data[v.e_tgt] = v.rdata;
         end
         #4;
         chk("tgt_valid", id, c, 32'(tgt_valids()),
             (c == 0 && v.e_tgt >= 0) ? (32'd1 << v.e_tgt) : 32'd0);
         if (c == 0 && v.e_tgt >= 0)
            chk("tgt_addr", id, c, bus.tgt_req[v.e_tgt].addr, v.addr);
         chk("core_done", id, c, 32'(bus.core_done), 32'(c == v.e_lat));
         chk("core_err", id, c, 32'(bus.core_err), 32'(c == v.e_lat && v.e_err));
         chk("core_data", id, c, bus.core_data, (c == v.e_lat) ? v.e_data : 32'd0);
         chk("busy", id, c, 32'(bus.busy), 32'(c >= 1 && c <= v.e_lat));
         tick();
      end
      $display("txn %0d addr=%h delay=%0d spur=%0d tgt=%0d lat=%0d err=%0d data=%h",
               id, v.addr, v.delay, v.spur, v.e_tgt, v.e_lat, v.e_err, v.e_data);
   endtask

   task automatic idle_cycles(input int id, input int n);
      for (int c = 0; c < n; c++) begin
         drive_noise();
         bus.core_req.valid = 1'b0;
         bus.tgt_done       = NT'($urandom);
         #4;
         chk("idle_done", id, c, 32'(bus.core_done), 32'd0);
         chk("idle_busy", id, c, 32'(bus.busy), 32'd0);
         chk("idle_data", id, c, bus.core_data, 32'd0);
         tick();
      end
   endtask

   task automatic check_quiet(input int id, input int c);
      chk("rst_done", id, c, 32'(bus.core_done), 32'd0);
      chk("rst_err", id, c, 32'(bus.core_err), 32'd0);
      chk("rst_data", id, c, bus.core_data, 32'd0);
      chk("rst_busy", id, c, 32'(bus.busy), 32'd0);
      chk("rst_tgt_valid", id, c, 32'(tgt_valids()), 32'd0);
   endtask

   vec_t vecs [10];

   initial begin
      vecs[0] = '{32'h0000_0010, 3,  32'h1234_5678, 1'b0, 0,  4,  1'b0, 32'h1234_5678};
      vecs[1] = '{32'h8000_0004, 0,  32'hA5A5_A5A5, 1'b0, 1,  1,  1'b0, 32'hA5A5_A5A5};
      vecs[2] = '{32'h4000_0000, -1, 32'h0000_0000, 1'b0, -1, 1,  1'b1, 32'hDEAD_BEEF};
      vecs[3] = '{32'h8000_0100, 70, 32'h5555_0000, 1'b0, 1,  65, 1'b1, 32'hDEAD_BEEF};
      vecs[4] = '{32'h8000_0008, 5,  32'h0BAD_F00D, 1'b1, 1,  6,  1'b0, 32'h0BAD_F00D};
      vecs[5] = '{32'h0000_0200, 64, 32'hC0DE_0064, 1'b0, 0,  65, 1'b0, 32'hC0DE_0064};
      vecs[6] = '{32'h8000_0300, 63, 32'hC0DE_0063, 1'b0, 1,  64, 1'b0, 32'hC0DE_0063};
      vecs[7] = '{32'h0000_0400, 65, 32'hC0DE_0065, 1'b0, 0,  65, 1'b1, 32'hDEAD_BEEF};
      vecs[8] = '{32'hF000_0000, -1, 32'h0000_0000, 1'b1, -1, 1,  1'b1, 32'hDEAD_BEEF};
      vecs[9] = '{32'h0FFF_FFFC, 1,  32'h0000_0001, 1'b1, 0,  2,  1'b0, 32'h0000_0001};

      // Reset held with a request presented: nothing may be forwarded.
      resetn = 1'b0;
      drive_noise();
      bus.core_req.valid = 1'b1;
      bus.core_req.addr  = 32'h0000_0010;
      tick();
      tick();
      #4;
      check_quiet(0, 0);
      tick();
      bus.core_req.valid = 1'b0;
      resetn = 1'b1;
      #4;
      check_quiet(0, 1);
      tick();

      for (int i = 0; i < 10; i++) begin
         run_vec(i + 1, vecs[i]);
         idle_cycles(i + 1, 1);
      end

      // Reset while waiting on target 0, then a stale response after release.
      drive_noise();
      bus.core_req.valid = 1'b1;
      bus.core_req.addr  = 32'h0000_0010;
      tick();
      bus.core_req.valid = 1'b0;
      tick();
      #4;
      chk("pre_rst_busy", 100, 1, 32'(bus.busy), 32'd1);
      tick();
      resetn = 1'b0;
      #1;
      check_quiet(100, 2);
      tick();
      resetn = 1'b1;
      bus.tgt_done[0] = 1'b1;
      bus.tgt_data[0] = 32'h7777_7777;
      #4;
      check_quiet(100, 3);
      tick();
      for (int c = 4; c < 8; c++) begin
         drive_noise();
         bus.core_req.valid = 1'b0;
         #4;
         check_quiet(100, c);
         tick();
      end
      $display("txn 100 reset in WAIT then stale tgt_done[0]");

      for (int n = 0; n < 40; n++) begin
         logic [31:0] addr;
         logic [3:0]  nib;
         int          region;
         int          delay;
         region = $urandom_range(0, 3);
         addr   = 32'($urandom);
         if (region == 0) begin
            nib = 4'h0;
         end else if (region == 1) begin
            nib = 4'h8;
         end else begin
            nib = 4'($urandom_range(1, 14));
            if (nib >= 4'h8) nib = nib + 4'h1;
         end
         addr[31:28] = nib;
         delay = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70))
                                             : int'($urandom_range(0, 6));
         run_vec(200 + n, model(addr, delay, 32'($urandom), 1'($urandom)));
         idle_cycles(200 + n, int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
